// File: rtl/vr_rr_arbiter_if.sv
// Purpose: bundles the upstream request side and downstream output side of vr_rr_arbiter.
// Latency: no logic here; the arbiter registers the output beat one cycle after an upstream fire.
// Backpressure: ready_down_in stalls the output register, and ready_up_out is then held low.
//
// Signals:
//   data_in        N*WIDTH  per-requester payload, requester i in [i*WIDTH +: WIDTH]
//   valid_up_in    N        per-requester valid
//   last_in        N        per-requester end-of-packet, qualified by valid_up_in
//   ready_up_out   N        per-requester ready (one-hot or zero)
//   data_out       WIDTH    registered payload to downstream
//   valid_down_out 1        registered valid to downstream
//   last_out       1        registered end-of-packet, travels with data_out
//   grant_id_out   IW       registered index of the requester that sourced data_out
//   ready_down_in  1        ready from downstream
// Modports: slave = arbiter side, master = the environment around it.
interface vr_rr_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N*WIDTH-1:0] data_in;
  logic [N-1:0]       valid_up_in;
  logic [N-1:0]       last_in;
  logic [N-1:0]       ready_up_out;
  logic [WIDTH-1:0]   data_out;
  logic               valid_down_out;
  logic               last_out;
  logic [IW-1:0]      grant_id_out;
  logic               ready_down_in;

  modport slave (
    input  data_in, valid_up_in, last_in, ready_down_in,
    output ready_up_out, data_out, valid_down_out, last_out, grant_id_out
  );

  modport master (
    output data_in, valid_up_in, last_in, ready_down_in,
    input  ready_up_out, data_out, valid_down_out, last_out, grant_id_out
  );
endinterface

// File: rtl/vr_rr_arbiter.sv
// Purpose: packet-aware round-robin arbiter, N valid/ready requesters into one registered output.
// Latency: one cycle from upstream fire to valid_down_out; one beat per cycle at full throughput.
// Backpressure: single output register; upstream ready only when that register is empty or draining.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - vr_rr_arbiter_if.slave (request inputs, ready_up_out, registered output beat)
//
// A requester whose beat is accepted with last_in low keeps the channel (LOCK) until it
// sends a beat with last_in high; the round-robin pointer then moves to the next index.
module vr_rr_arbiter #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic           clk,
  input  logic           rst,
  vr_rr_arbiter_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]       state;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    ptr;

  logic             load_en;
  logic [N-1:0]     grant;
  logic [IW-1:0]    sel_idx;
  logic             found;
  logic [IW:0]      idx;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;
  logic             up_fire;

  // Output register can take a new beat when empty or being drained this cycle.
  assign load_en = !bus.valid_down_out | bus.ready_down_in;

  // Grant selection. idx carries one spare bit so ptr+k can be folded back
  // below N without requiring N to be a power of two.
  always_comb begin
    grant   = '0;
    sel_idx = '0;
    found   = 1'b0;
    idx     = '0;
    if (!rst) begin
      if (state == ST_ARB) begin
        for (int k = 0; k < N; k++) begin
          idx = {1'b0, ptr} + (IW+1)'(k);
          if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
          if (!found && bus.valid_up_in[idx[IW-1:0]]) begin
            found                = 1'b1;
            grant[idx[IW-1:0]]   = 1'b1;
            sel_idx              = idx[IW-1:0];
          end
        end
      end else if (bus.valid_up_in[owner]) begin
        grant[owner] = 1'b1;
        sel_idx      = owner;
      end
    end
  end

  assign bus.ready_up_out = grant & {N{load_en}};
  assign up_fire          = |bus.ready_up_out;

  // Payload mux keyed off the one-hot grant; data only feeds the register.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (grant[k]) begin
        sel_data = bus.data_in[k*WIDTH +: WIDTH];
        sel_last = bus.last_in[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_ARB;
      owner              <= '0;
      ptr                <= '0;
      bus.valid_down_out <= 1'b0;
      bus.data_out       <= '0;
      bus.last_out       <= 1'b0;
      bus.grant_id_out   <= '0;
    end else if (up_fire) begin
      bus.valid_down_out <= 1'b1;
      bus.data_out       <= sel_data;
      bus.last_out       <= sel_last;
      bus.grant_id_out   <= sel_idx;
      if (sel_last) begin
        state <= ST_ARB;
        ptr   <= (sel_idx == IW'(N-1)) ? '0 : sel_idx + IW'(1);
      end else begin
        state <= ST_LOCK;
        owner <= sel_idx;
      end
    end else if (bus.ready_down_in) begin
      // Drain: payload fields hold, only valid drops.
      bus.valid_down_out <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vr_rr_arbiter.sv
module tb_vr_rr_arbiter;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  vr_rr_arbiter_if #(.WIDTH(32), .N(4)) ifa ();
  vr_rr_arbiter_if #(.WIDTH(8),  .N(3)) ifb ();

  vr_rr_arbiter #(.WIDTH(32), .N(4)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
  vr_rr_arbiter #(.WIDTH(8),  .N(3)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the registered output of dut_a.
  task automatic chk_out(input string tag, input logic v, input logic [1:0] gid);
    chk({tag, ".valid"}, 64'(ifa.valid_down_out), 64'(v));
    chk({tag, ".gid"},   64'(ifa.grant_id_out),   64'(gid));
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.data_in       = '0;
    ifa.valid_up_in   = '0;
    ifa.last_in       = '0;
    ifa.ready_down_in = 1'b1;
    ifb.data_in       = '0;
    ifb.valid_up_in   = '0;
    ifb.last_in       = '0;
    ifb.ready_down_in = 1'b1;
    tick();
    tick();

    // Reset state, and ready stays low while rst is high even with requests.
    ifa.valid_up_in = 4'b1111;
    #1;
    chk("rst.ready_up", 64'(ifa.ready_up_out), 64'h0);
    chk("rst.data",     64'(ifa.data_out),     64'h0);
    chk("rst.last",     64'(ifa.last_out),     64'h0);
    chk_out("rst", 1'b0, 2'd0);

    // All four requesters, single-beat packets, downstream always ready.
    for (int i = 0; i < 4; i++) ifa.data_in[i*32 +: 32] = 32'h1000 + 32'(i);
    ifa.last_in = 4'b1111;
    rst_a = 1'b0;
    #1;
    chk("rr.ready0", 64'(ifa.ready_up_out), 64'b0001);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out("rr", 1'b1, 2'(k % 4));
      chk("rr.data", 64'(ifa.data_out), 64'h1000 + 64'(k % 4));
    end
    // ptr is now 1.

    // Requester 1 sends a 3-beat packet while requester 2 stays valid.
    ifa.valid_up_in = 4'b0110;
    ifa.last_in     = 4'b0100;
    #1;
    chk("pkt.ready_b1", 64'(ifa.ready_up_out), 64'b0010);
    tick();
    chk_out("pkt.b1", 1'b1, 2'd1);
    chk("pkt.b1.last", 64'(ifa.last_out), 64'h0);
    chk("pkt.ready_b2", 64'(ifa.ready_up_out), 64'b0010);
    tick();
    chk_out("pkt.b2", 1'b1, 2'd1);
    ifa.last_in = 4'b0110;
    #1;
    chk("pkt.ready_b3", 64'(ifa.ready_up_out), 64'b0010);
    tick();
    chk_out("pkt.b3", 1'b1, 2'd1);
    chk("pkt.b3.last", 64'(ifa.last_out), 64'h1);
    chk("pkt.ready_next", 64'(ifa.ready_up_out), 64'b0100);
    tick();
    chk_out("pkt.next", 1'b1, 2'd2);
    // ptr is now 3.

    // Lock on requester 0, then it deasserts valid while requester 3 waits.
    ifa.valid_up_in = 4'b0001;
    ifa.last_in     = 4'b0000;
    tick();
    chk_out("lock.b1", 1'b1, 2'd0);
    ifa.valid_up_in = 4'b1000;
    ifa.last_in     = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lock.stall.ready", 64'(ifa.ready_up_out), 64'h0);
      tick();
      chk_out("lock.stall", 1'b0, 2'd0);
    end
    ifa.valid_up_in = 4'b1001;
    ifa.last_in     = 4'b1001;
    #1;
    chk("lock.reval.ready", 64'(ifa.ready_up_out), 64'b0001);
    tick();
    chk_out("lock.reval", 1'b1, 2'd0);
    chk("lock.reval.last", 64'(ifa.last_out), 64'h1);
    // ptr is now 1.

    // Backpressure: hold beat A5A5_0001 for 5 cycles, then A5A5_0002 with no bubble.
    ifa.valid_up_in = 4'b0010;
    ifa.last_in     = 4'b0010;
    ifa.data_in[32 +: 32] = 32'hA5A5_0001;
    tick();
    chk("bp.load", 64'(ifa.data_out), 64'hA5A5_0001);
    ifa.ready_down_in = 1'b0;
    ifa.data_in[32 +: 32] = 32'hA5A5_0002;
    ifa.valid_up_in = 4'b0110;
    ifa.last_in     = 4'b0110;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp.ready", 64'(ifa.ready_up_out), 64'h0);
      tick();
      chk("bp.data", 64'(ifa.data_out), 64'hA5A5_0001);
      chk_out("bp", 1'b1, 2'd1);
    end
    ifa.ready_down_in = 1'b1;
    ifa.valid_up_in   = 4'b0010;
    #1;
    chk("bp.release.ready", 64'(ifa.ready_up_out), 64'b0010);
    tick();
    chk("bp.next.data", 64'(ifa.data_out), 64'hA5A5_0002);
    chk_out("bp.next", 1'b1, 2'd1);
    // ptr is now 2. Drain with no requests: valid drops, payload holds.
    ifa.valid_up_in = 4'b0000;
    tick();
    chk_out("drain", 1'b0, 2'd1);
    chk("drain.data", 64'(ifa.data_out), 64'hA5A5_0002);

    // Reset in LOCK(owner=3) with a held output beat.
    ifa.valid_up_in = 4'b1000;
    ifa.last_in     = 4'b0000;
    ifa.data_in[96 +: 32] = 32'hDEAD_0003;
    tick();
    chk_out("rstlock.b1", 1'b1, 2'd3);
    rst_a = 1'b1;
    ifa.valid_up_in = 4'b1010;
    #1;
    chk("rstlock.ready", 64'(ifa.ready_up_out), 64'h0);
    tick();
    chk_out("rstlock.after", 1'b0, 2'd0);
    chk("rstlock.data", 64'(ifa.data_out), 64'h0);
    rst_a = 1'b0;
    #1;
    chk("rstlock.ready_post", 64'(ifa.ready_up_out), 64'b0010);
    tick();
    chk_out("rstlock.grant", 1'b1, 2'd1);

    // N=3: pointer wraps from 2 to 0.
    rst_b = 1'b0;
    ifb.valid_up_in = 3'b010;
    ifb.last_in     = 3'b111;
    tick();
    chk("n3.g1", 64'(ifb.grant_id_out), 64'd1);
    ifb.valid_up_in = 3'b100;
    #1;
    chk("n3.ready2", 64'(ifb.ready_up_out), 64'b100);
    tick();
    chk("n3.g2", 64'(ifb.grant_id_out), 64'd2);
    ifb.valid_up_in = 3'b011;
    #1;
    chk("n3.ready_wrap", 64'(ifb.ready_up_out), 64'b001);
    tick();
    chk("n3.g0", 64'(ifb.grant_id_out), 64'd0);
    chk("n3.valid", 64'(ifb.valid_down_out), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vr_rr_arbiter.md
VR_RR_ARBITER -- requirements
Module: vr_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits per channel.
REQ-002 Parameter N, default 4, number of upstream requesters; legal range 2..16; IW = max(1, clog2(N)).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 data_in  input  N*WIDTH  payload of requester i in bits [i*WIDTH +: WIDTH].
REQ-006 valid_up_in  input  N  per-requester valid, from upstream nodes.
REQ-007 last_in  input  N  per-requester end-of-packet marker, qualified by valid_up_in[i].
REQ-008 ready_up_out  output  N  per-requester ready, to upstream nodes.
REQ-009 data_out  output  WIDTH  registered payload to the downstream node.
REQ-010 valid_down_out  output  1  registered valid to the downstream node.
REQ-011 last_out  output  1  registered end-of-packet marker, travels with data_out.
REQ-012 grant_id_out  output  IW  registered index of the requester that sourced the current output beat.
REQ-013 ready_down_in  input  1  ready from the downstream node.

Function
REQ-014 An upstream fire on channel i is valid_up_in[i] & ready_up_out[i]; a downstream fire is valid_down_out & ready_down_in.
REQ-015 Output stage is a one-entry register; load_en = !valid_down_out | ready_down_in, computed combinationally.
REQ-016 At most one ready_up_out bit is high in any cycle; ready_up_out[i] = load_en & grant[i], grant one-hot or zero.
REQ-017 ready_up_out may depend combinationally on valid_up_in and ready_down_in; no output depends combinationally on data_in.
REQ-018 State machine has two states: ARB and LOCK(owner); reset state ARB.
REQ-019 In ARB, grant selects the first i with valid_up_in[i] high, scanning ptr, ptr+1, ..., wrapping modulo N (N need not be a power of two).
REQ-020 In LOCK, grant = one-hot(owner) if valid_up_in[owner] is high, else zero; other requesters stall even if valid.
REQ-021 On an upstream fire from i with last_in[i] = 0: next state LOCK(owner = i).
REQ-022 On an upstream fire from i with last_in[i] = 1: next state ARB and ptr <= (i + 1) mod N, with i = N-1 wrapping to 0.
REQ-023 ptr changes only as in REQ-022; it holds otherwise, including across LOCK.
REQ-024 On an upstream fire: data_out <= data_in[i], last_out <= last_in[i], grant_id_out <= i, valid_down_out <= 1; latency is exactly one cycle.
REQ-025 Downstream fire with no simultaneous upstream fire: valid_down_out <= 0, data_out/last_out/grant_id_out hold.
REQ-026 Downstream fire and upstream fire in the same cycle: the new beat is loaded, valid_down_out stays 1, no bubble; full throughput of one beat per cycle.
REQ-027 While valid_down_out = 1 and ready_down_in = 0, data_out, last_out, grant_id_out and valid_down_out hold stable, and ready_up_out = 0.
REQ-028 No requests (valid_up_in = 0): no state, ptr or output change except the drain of REQ-025.

Reset
REQ-029 With rst high at a clock edge: valid_down_out <= 0, data_out <= 0, last_out <= 0, grant_id_out <= 0, ptr <= 0, state <= ARB.
REQ-030 While rst is high, ready_up_out = 0 combinationally.
REQ-031 Reset asserted mid-packet discards the lock and any held output beat; the first post-reset grant follows REQ-019 from ptr = 0.

Verification
REQ-032 N=4: valid_up_in=4'b1111, all last_in=1, ready_down_in=1 held -> grant_id_out sequence 0,1,2,3,0 on consecutive cycles, valid_down_out continuously 1 from cycle 1.
REQ-033 N=4: req 1 sends a 3-beat packet (last on beat 3) while req 2 stays valid -> outputs are 1,1,1 then 2; ptr=2 after the packet, ready_up_out[2]=0 during the packet.
REQ-034 ready_down_in=0 for 5 cycles with beat 0xA5A5_0001 held -> data_out stable 0xA5A5_0001 and ready_up_out=0 all 5 cycles; beat 0xA5A5_0002 appears in the cycle after ready_down_in returns to 1, with no bubble.
REQ-035 N=3: ptr=2 and req 2 sends a single beat -> ptr wraps to 0; next grant with valid_up_in=3'b011 is req 0.
REQ-036 rst pulsed for 1 cycle in LOCK(owner=3) with valid_down_out=1 -> next cycle valid_down_out=0, grant_id_out=0, ptr=0; with valid_up_in=4'b1010 the next grant is req 1.
REQ-037 In LOCK(owner=0) with valid_up_in[0]=0 for 3 cycles and valid_up_in[3]=1 -> ready_up_out=0, no beat loaded, until req 0 revalidates.
